lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: MEM_WORDS, 64, number of 32-bit words in the downstream data RAM; legal byte addresses are 0 .. 4*MEM_WORDS-1.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  in  1  memory-stage request present.
REQ-005 Port: req_load / req_store  in  1 each  operation type; exactly one shall be high for a legal request.
REQ-006 Port: req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 Port: req_signed  in  1  sign-extend sub-word load result when high, zero-extend when low.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data, right-justified for sub-word stores.
REQ-010 Port: req_ready  out  1  high only in IDLE; a request is accepted on a rising edge when req_valid and req_ready are both high.
REQ-011 Port: resp_valid  out  1  one-cycle completion pulse, exactly one per accepted request.
REQ-012 Port: resp_rdata  out  32  load result; 0 for stores and errors.
REQ-013 Port: resp_err  out  1  qualified by resp_valid; flags a misaligned, out-of-range or illegal request.
REQ-014 Port: ram_address  out  32  word-aligned byte address to the RAM (bits 1:0 always 0).
REQ-015 Port: ram_data_write  out  32  RAM write data.
REQ-016 Port: ram_write_en / ram_read_en  out  1 each  RAM strobes.
REQ-017 Port: ram_data_out  in  32  combinational RAM read data, valid in the same cycle as ram_read_en.

Function
REQ-018 States SHALL be IDLE, MERGE and RESP; resp_valid SHALL be high exactly in RESP; RESP SHALL always return to IDLE.
REQ-019 Byte lanes SHALL be little-endian: lane n = bits 8n+7:8n, selected by addr[1:0]; a half selects lanes addr[1]*2 and addr[1]*2+1.
REQ-020 Error check in IDLE: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*MEM_WORDS; load and store both high or both low -> no RAM strobe; go to RESP with resp_err=1 and resp_rdata=0.
REQ-021 Load: in the accept cycle, drive ram_read_en=1 and ram_address=addr&~3; register the extracted and extended lane(s) into resp_rdata; go to RESP (latency 1).
REQ-022 Word store: in the accept cycle, drive ram_write_en=1 and ram_data_write=req_wdata; go to RESP (latency 1).
REQ-023 Sub-word store: in the accept cycle, drive ram_read_en=1 and latch ram_data_out, addr and wdata; go to MERGE. In MERGE, drive ram_write_en=1 with the latched word, target lane(s) replaced; go to RESP (latency 2).
REQ-024 ram_write_en SHALL never be high outside the two write cycles defined above; ram_read_en SHALL never be high in MERGE or RESP.
REQ-025 Request inputs are ignored while req_ready=0; no second request is accepted until after RESP (throughput: one request per 2 or 3 cycles).
REQ-026 When idle with no request, the RAM strobes SHALL be 0 and ram_address SHALL be 0.

Reset
REQ-027 While reset is high: state=IDLE; req_ready=0; and resp_valid, resp_err, resp_rdata, ram_write_en, ram_read_en, ram_address and ram_data_write are all 0.
REQ-028 Reset asserted in MERGE SHALL suppress the pending write: no partial store reaches the RAM, and no resp_valid is produced for the aborted request.
REQ-029 After reset deasserts, req_ready SHALL be 1 from the next cycle.

Structure
REQ-030 Package mips_mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the LSU state encoding.
REQ-031 One combinational sub-module, lsu_lane_align, SHALL perform lane extraction with sign/zero extension and lane merge; lsu_ctrl holds the FSM and registers.

Verification
REQ-032 Word load: RAM[1]=0x8001F0E2; load word at 0x4 -> resp_valid 1 cycle after accept, rdata=0x8001F0E2, err=0.
REQ-033 Signed and unsigned byte loads: same word; signed byte at 0x7 -> 0xFFFFFF80; unsigned byte at 0x7 -> 0x00000080; signed half at 0x4 -> 0xFFFFF0E2.
REQ-034 Sub-word store: RAM[2]=0x11223344; store byte 0xAB at 0x9 -> exactly one read then one write; RAM[2]=0x1122AB44; resp_valid 2 cycles after accept.
REQ-035 Errors: half store at 0x3, word load at 0x102 (MEM_WORDS=64), req_size=11 -> no RAM strobes; resp_err=1 each time; RAM unchanged.
REQ-036 Reset mid-op: assert reset in the MERGE cycle of a byte store to 0x10 -> RAM[4] unchanged; no resp_valid; req_ready=1 in the first cycle after reset release.
REQ-037 Back-to-back: hold req_valid with 3 queued loads -> exactly 3 resp_valid pulses, none in adjacent cycles; req_ready=0 in every RESP cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMerge = 2'd1,
    StResp  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Memory-stage request/response handshake plus the downstream data RAM port.
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_address;
  logic [31:0] ram_data_write;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [31:0] ram_data_out;

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
    input  ram_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_address, ram_data_write, ram_write_en, ram_read_en
  );

  modport master (
    output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
    output ram_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_address, ram_data_write, ram_write_en, ram_read_en
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction with sign/zero extension, and lane merge for sub-word stores.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = word_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    merge_data_o = word_i;
    case (size_i)
      SZ_BYTE: merge_data_o[{offset_i, 3'b000} +: 8]    = wdata_i[7:0];
      SZ_HALF: merge_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: validates requests, drives the data RAM and returns one response each.
// Sub-word stores are read-modify-write through the MERGE state.
module lsu_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic           clk,
  input  logic           reset,
  lsu_ctrl_if.slave      bus
);

  localparam logic [31:0] AddrLimit = 32'(4 * MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;

  logic        accept;
  logic        req_bad;
  logic        in_merge;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign in_merge = (state_q == StMerge);

  assign req_bad = (bus.req_size == 2'b11)
                || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                || (bus.req_addr >= AddrLimit)
                || (bus.req_load == bus.req_store);

  // One aligner serves both the load path (live RAM data) and the merge (latched word).
  lsu_lane_align u_align (
    .word_i       (in_merge ? word_q        : bus.ram_data_out),
    .wdata_i      (in_merge ? wdata_q       : bus.req_wdata),
    .offset_i     (in_merge ? addr_q[1:0]   : bus.req_addr[1:0]),
    .size_i       (in_merge ? size_q        : bus.req_size),
    .signed_i     (bus.req_signed),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_comb begin
    state_d            = state_q;
    rdata_d            = '0;
    err_d              = 1'b0;
    word_d             = word_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    size_d             = size_q;
    bus.ram_address    = '0;
    bus.ram_data_write = '0;
    bus.ram_write_en   = 1'b0;
    bus.ram_read_en    = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StResp;
          if (req_bad) begin
            err_d = 1'b1;
          end else if (bus.req_load) begin
            bus.ram_read_en = 1'b1;
            bus.ram_address = {bus.req_addr[31:2], 2'b00};
            rdata_d         = load_data;
          end else if (bus.req_size == SZ_WORD) begin
            bus.ram_write_en   = 1'b1;
            bus.ram_address    = {bus.req_addr[31:2], 2'b00};
            bus.ram_data_write = bus.req_wdata;
          end else begin
            bus.ram_read_en = 1'b1;
            bus.ram_address = {bus.req_addr[31:2], 2'b00};
            word_d          = bus.ram_data_out;
            addr_d          = bus.req_addr;
            wdata_d         = bus.req_wdata;
            size_d          = bus.req_size;
            state_d         = StMerge;
          end
        end
      end
      StMerge: begin
        bus.ram_write_en   = 1'b1;
        bus.ram_address    = {addr_q[31:2], 2'b00};
        bus.ram_data_write = merge_data;
        state_d            = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small behavioural data RAM and strobe counters.
module tb_lsu_ctrl;

  logic clk;
  logic reset;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int checks;
  int failures;
  int read_cnt, write_cnt, resp_cnt, adj_cnt, rdy_resp_cnt, acc_cnt;
  logic prev_resp;

  assign bus.ram_data_out = mem[bus.ram_address[7:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.ram_write_en) mem[bus.ram_address[7:2]] <= bus.ram_data_write;
    read_cnt     <= read_cnt + int'(bus.ram_read_en);
    write_cnt    <= write_cnt + int'(bus.ram_write_en);
    resp_cnt     <= resp_cnt + int'(bus.resp_valid);
    adj_cnt      <= adj_cnt + int'(bus.resp_valid && prev_resp);
    rdy_resp_cnt <= rdy_resp_cnt + int'(bus.resp_valid && bus.req_ready);
    acc_cnt      <= acc_cnt + int'(bus.req_valid && bus.req_ready);
    prev_resp    <= bus.resp_valid;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
    bus.req_load = ld; bus.req_store = st; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
  endtask

  // Issue one request and wait (bounded) for its response; lat counts cycles after accept.
  task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er, output logic rdy);
    @(negedge clk);
    drive_req(ld, st, sz, sg, a, wd);
    bus.req_valid = 1'b1;
    rdy = bus.req_ready;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 6);
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 6;
    if (bus.req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%0b want=0", bus.req_ready);
    end
    if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
      failures++; $display("FAIL reset_resp got=%0b/%0b want=0/0", bus.resp_valid, bus.resp_err);
    end
    if (bus.resp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h want=0", bus.resp_rdata);
    end
    if (bus.ram_read_en !== 1'b0 || bus.ram_write_en !== 1'b0) begin
      failures++; $display("FAIL reset_strobes got=%0b/%0b want=0/0",
                           bus.ram_read_en, bus.ram_write_en);
    end
    if (bus.ram_address !== 32'h0) begin
      failures++; $display("FAIL reset_addr got=%h want=0", bus.ram_address);
    end
    if (bus.ram_data_write !== 32'h0) begin
      failures++; $display("FAIL reset_wdata got=%h want=0", bus.ram_data_write);
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL release_ready got=%0b want=1", bus.req_ready);
    end
    if (bus.ram_address !== 32'h0 || bus.ram_read_en !== 1'b0 || bus.ram_write_en !== 1'b0) begin
      failures++; $display("FAIL idle_bus got addr=%h rd=%0b wr=%0b want 0/0/0",
                           bus.ram_address, bus.ram_read_en, bus.ram_write_en);
    end
  endtask

  task automatic test_word_load;
    int lat; logic [31:0] rd; logic er, rdy;
    preload(6'd1, 32'h8001F0E2);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, rdy);
    checks += 2;
    if (lat != 1 || rdy !== 1'b1) begin
      failures++; $display("FAIL word_load_lat got=%0d rdy=%0b want=1 rdy=1", lat, rdy);
    end
    if (rd !== 32'h8001F0E2 || er !== 1'b0) begin
      failures++; $display("FAIL word_load_data got=%h err=%0b want=8001f0e2 err=0", rd, er);
    end
  endtask

  task automatic test_sub_loads;
    logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [5] = '{32'h7, 32'h7, 32'h4, 32'h6, 32'hFF};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF0E2, 32'h00008001,
                             32'hFFFFFFA5};
    int lat; logic [31:0] rd; logic er, rdy;
    preload(6'd63, 32'hA5000000);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er, rdy);
      checks++;
      if (rd !== exp[i] || er !== 1'b0 || lat != 1) begin
        failures++;
        $display("FAIL sub_load_%0d got=%h err=%0b lat=%0d want=%h err=0 lat=1",
                 i, rd, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_store;
    int lat, r0, w0; logic [31:0] rd; logic er, rdy;
    preload(6'd2, 32'h11223344);
    r0 = read_cnt; w0 = write_cnt;
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AB, lat, rd, er, rdy);
    checks += 3;
    if (read_cnt - r0 != 1 || write_cnt - w0 != 1) begin
      failures++; $display("FAIL byte_store_strobes got rd=%0d wr=%0d want 1/1",
                           read_cnt - r0, write_cnt - w0);
    end
    if (mem[2] !== 32'h1122AB44) begin
      failures++; $display("FAIL byte_store_mem got=%h want=1122ab44", mem[2]);
    end
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL byte_store_resp got lat=%0d err=%0b rd=%h want 2/0/0",
                           lat, er, rd);
    end
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h1234BEEF, lat, rd, er, rdy);
    checks++;
    if (mem[2] !== 32'hBEEFAB44 || lat != 2) begin
      failures++; $display("FAIL half_store got=%h lat=%0d want=beefab44 lat=2", mem[2], lat);
    end
    r0 = read_cnt; w0 = write_cnt;
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D, lat, rd, er, rdy);
    checks += 2;
    if (mem[3] !== 32'hCAFEF00D || lat != 1 || er !== 1'b0) begin
      failures++; $display("FAIL word_store got=%h lat=%0d err=%0b want=cafef00d 1 0",
                           mem[3], lat, er);
    end
    if (read_cnt - r0 != 0 || write_cnt - w0 != 1) begin
      failures++; $display("FAIL word_store_strobes got rd=%0d wr=%0d want 0/1",
                           read_cnt - r0, write_cnt - w0);
    end
  endtask

  task automatic test_errors;
    logic        ld [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        st [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [31:0] ad [5] = '{32'h3, 32'h102, 32'h0, 32'h8, 32'h100};
    logic [31:0] snap [64];
    int lat, r0, w0, diff; logic [31:0] rd; logic er, rdy;
    for (int i = 0; i < 5; i++) begin
      snap = mem;
      r0 = read_cnt; w0 = write_cnt;
      do_req(ld[i], st[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF, lat, rd, er, rdy);
      diff = 0;
      for (int k = 0; k < 64; k++) if (mem[k] !== snap[k]) diff++;
      checks += 2;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
        failures++; $display("FAIL err_resp_%0d got err=%0b rd=%h lat=%0d want 1/0/1",
                             i, er, rd, lat);
      end
      if (read_cnt != r0 || write_cnt != w0 || diff != 0) begin
        failures++; $display("FAIL err_side_%0d got rd=%0d wr=%0d diff=%0d want 0/0/0",
                             i, read_cnt - r0, write_cnt - w0, diff);
      end
    end
  endtask

  task automatic test_reset_mid;
    int w0, rs0;
    preload(6'd4, 32'h55667788);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000099);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    w0 = write_cnt; rs0 = resp_cnt;
    @(negedge clk);
    checks++;
    if (bus.ram_write_en !== 1'b1) begin
      failures++; $display("FAIL merge_write got=%0b want=1", bus.ram_write_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ram_write_en !== 1'b0 || bus.ram_address !== 32'h0) begin
      failures++; $display("FAIL mid_reset_bus got wr=%0b addr=%h want 0/0",
                           bus.ram_write_en, bus.ram_address);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_ready got=%0b want=1", bus.req_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem[4] !== 32'h55667788 || write_cnt != w0 || resp_cnt != rs0) begin
      failures++; $display("FAIL mid_reset_effect got mem=%h wr=%0d resp=%0d want 55667788 0 0",
                           mem[4], write_cnt - w0, resp_cnt - rs0);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz  [3] = '{2'b10, 2'b00, 2'b01};
    logic        sg  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ad  [3] = '{32'h4, 32'h5, 32'h6};
    logic [31:0] exp [3] = '{32'h8001F0E2, 32'h000000F0, 32'hFFFF8001};
    int a0, rs0, adj0, rr0, idx, got;
    a0 = acc_cnt; rs0 = resp_cnt; adj0 = adj_cnt; rr0 = rdy_resp_cnt;
    got = 0;
    @(negedge clk);
    drive_req(1'b1, 1'b0, sz[0], sg[0], ad[0], 32'h0);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        checks++;
        if (bus.resp_rdata !== exp[got] || bus.resp_err !== 1'b0) begin
          failures++; $display("FAIL b2b_data_%0d got=%h err=%0b want=%h err=0",
                               got, bus.resp_rdata, bus.resp_err, exp[got]);
        end
        got++;
      end
      idx = acc_cnt - a0;
      if (idx < 3) drive_req(1'b1, 1'b0, sz[idx], sg[idx], ad[idx], 32'h0);
      else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (got != 3 || resp_cnt - rs0 != 3 || acc_cnt - a0 != 3) begin
      failures++; $display("FAIL b2b_count got seen=%0d resp=%0d acc=%0d want 3/3/3",
                           got, resp_cnt - rs0, acc_cnt - a0);
    end
    if (adj_cnt != adj0) begin
      failures++; $display("FAIL b2b_adjacent got=%0d want=0", adj_cnt - adj0);
    end
    if (rdy_resp_cnt != rr0) begin
      failures++; $display("FAIL b2b_ready_in_resp got=%0d want=0", rdy_resp_cnt - rr0);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    read_cnt = 0; write_cnt = 0; resp_cnt = 0; adj_cnt = 0;
    rdy_resp_cnt = 0; acc_cnt = 0; prev_resp = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    reset = 1'b1;
    // A request is presented during reset to confirm it is ignored.
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    bus.req_valid = 1'b1;
    test_reset;
    test_word_load;
    test_sub_loads;
    test_store;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
